// File: rtl/scurve_pkg.sv
// Shared S-curve stream constants: framing words, channel tags, DAC nibble
// and record mode encodings. Also used by the test controller.
package scurve_pkg;

    localparam logic [15:0] SC_HEADER  = 16'h5343;
    localparam logic [15:0] SC_TRAILER = 16'hFF45;

    localparam logic [7:0] TAG_64 = 8'h63;
    localparam logic [7:0] TAG_SC = 8'h43;
    localparam logic [7:0] TAG_SI = 8'h49;

    localparam logic [3:0] DAC_NIB = 4'hD;

    localparam logic [1:0] MODE_64 = 2'd0;
    localparam logic [1:0] MODE_SC = 2'd1;
    localparam logic [1:0] MODE_SI = 2'd2;

    typedef enum logic [2:0] {
        HUNT,
        CHN,
        DAC,
        DATA,
        NEXT
    } state_t;

    function automatic logic chn_ok(input logic [15:0] w);
        return (w[15:8] == TAG_64 || w[15:8] == TAG_SC ||
                w[15:8] == TAG_SI) && (w[7:6] == 2'b00);
    endfunction

    function automatic logic [1:0] tag_mode(input logic [7:0] tag);
        logic [1:0] m;
        case (tag)
            TAG_64:  m = MODE_64;
            TAG_SC:  m = MODE_SC;
            default: m = MODE_SI;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/scurve_fifo_reader.sv
// Single-outstanding FIFO read engine: one strobe, data valid next cycle,
// never more than one word in flight.
module scurve_fifo_reader (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_dout,
    input  logic        stall,
    output logic        fifo_rd_en,
    output logic [15:0] word,
    output logic        word_v
);

    logic live;

    // live keeps the strobe low while reset is held
    assign fifo_rd_en = live & ~fifo_empty & ~word_v & ~stall;
    assign word       = fifo_dout;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            live   <= 1'b0;
            word_v <= 1'b0;
        end else begin
            live   <= 1'b1;
            word_v <= fifo_rd_en;
        end
    end

endmodule

// File: rtl/scurve_stream_parser.sv
// S-curve stream parser: rebuilds per-DAC-point records from the FIFO stream.
// Optional DAC/channel sequence checking via SCURVE_PARSER_SEQCHK_EN.
module scurve_stream_parser
    import scurve_pkg::*;
#(
    parameter int          DATA_WORDS   = 2,
    parameter logic [15:0] HEADER_WORD  = SC_HEADER,
    parameter logic [15:0] TRAILER_WORD = SC_TRAILER
) (
    input  logic                     Clk,
    input  logic                     reset_n,
    input  logic                     fifo_empty,
    input  logic [15:0]              fifo_dout,
    output logic                     fifo_rd_en,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [1:0]               rec_mode,
    output logic [5:0]               rec_chn,
    output logic [9:0]               rec_dac,
    output logic [16*DATA_WORDS-1:0] rec_data,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic [15:0]              point_cnt
`ifdef SCURVE_PARSER_SEQCHK_EN
    ,
    output logic                     seq_err
`endif
);

    localparam int IW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    state_t        state, state_d;
    logic [15:0]   word;
    logic          word_v, stall, accept;
    logic          is_hdr, is_trl, is_chn, is_dac, last_w;
    logic          err_ev, hdr_ev, chn_ev, dac_ev, dat_ev, done_ev;
    logic [IW-1:0] idx;

    scurve_fifo_reader u_reader (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .stall     (stall),
        .fifo_rd_en(fifo_rd_en),
        .word      (word),
        .word_v    (word_v)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= HUNT;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        err_ev  = 1'b0;
        hdr_ev  = 1'b0;
        chn_ev  = 1'b0;
        dac_ev  = 1'b0;
        dat_ev  = 1'b0;
        done_ev = 1'b0;
        if (word_v) begin
            case (state)
                HUNT: if (is_hdr) begin
                    hdr_ev  = 1'b1;
                    state_d = CHN;
                end
                CHN: if (is_chn) begin
                    chn_ev  = 1'b1;
                    state_d = DAC;
                end else begin
                    err_ev = 1'b1;
                end
                DAC: if (is_dac) begin
                    dac_ev  = 1'b1;
                    state_d = DATA;
                end else begin
                    err_ev = 1'b1;
                end
                DATA: begin
                    dat_ev = 1'b1;
                    if (last_w) state_d = NEXT;
                end
                NEXT: unique case (1'b1)
                    is_dac: begin
                        dac_ev  = 1'b1;
                        state_d = DATA;
                    end
                    is_chn: begin
                        chn_ev  = 1'b1;
                        state_d = DAC;
                    end
                    is_trl: begin
                        done_ev = 1'b1;
                        state_d = HUNT;
                    end
                    is_hdr: begin
                        err_ev  = 1'b1;
                        hdr_ev  = 1'b1;
                        state_d = CHN;
                    end
                    default: err_ev = 1'b1;
                endcase
                default: state_d = HUNT;
            endcase
            // a header seen after a record restarts the frame instead of hunting
            if (err_ev && !hdr_ev) state_d = HUNT;
        end
    end

    always_comb begin
        is_hdr = (word == HEADER_WORD);
        is_trl = (word == TRAILER_WORD);
        is_chn = chn_ok(word);
        is_dac = (word[15:12] == DAC_NIB) && (word[11:10] == 2'b00);
        last_w = (idx == IW'(DATA_WORDS - 1));
        accept = rec_valid & rec_ready;
        stall  = rec_valid & ~rec_ready;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_valid  <= 1'b0;
            rec_mode   <= '0;
            rec_chn    <= '0;
            rec_dac    <= '0;
            rec_data   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            point_cnt  <= '0;
            idx        <= '0;
        end else begin
            frame_done <= done_ev;
            if (hdr_ev) frame_err <= 1'b0;
            if (err_ev) frame_err <= 1'b1;
            if (chn_ev) begin
                rec_mode <= tag_mode(word[15:8]);
                rec_chn  <= word[5:0];
            end
            if (dac_ev) begin
                rec_dac <= word[9:0];
                idx     <= '0;
            end
            if (dat_ev) begin
                rec_data[16*idx +: 16] <= word;
                idx                    <= idx + 1'b1;
            end
            if (dat_ev && last_w) rec_valid <= 1'b1;
            else if (accept)      rec_valid <= 1'b0;
            if (hdr_ev)
                point_cnt <= '0;
            else if (accept && point_cnt != 16'hFFFF)
                point_cnt <= point_cnt + 16'd1;
        end
    end

`ifdef SCURVE_PARSER_SEQCHK_EN
    logic [10:0] dac_exp;
    logic [6:0]  chn_exp;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_err <= 1'b0;
            dac_exp <= '0;
            chn_exp <= '0;
        end else begin
            if (hdr_ev) begin
                seq_err <= 1'b0;
                chn_exp <= '0;
            end
            if (chn_ev) begin
                dac_exp <= '0;
                if (state == NEXT && rec_dac != 10'h3FF) seq_err <= 1'b1;
                if (tag_mode(word[15:8]) == MODE_64) begin
                    if ({1'b0, word[5:0]} != chn_exp) seq_err <= 1'b1;
                    chn_exp <= {1'b0, word[5:0]} + 7'd1;
                end
            end
            if (dac_ev) begin
                if ({1'b0, word[9:0]} != dac_exp) seq_err <= 1'b1;
                dac_exp <= {1'b0, word[9:0]} + 11'd1;
            end
        end
    end
`endif

endmodule

// File: doc/scurve_stream_parser.md
Name: scurve_stream_parser

Overview:
Consumes the 16-bit S-curve result stream emitted toward the USB data FIFO and decodes it back into per-DAC-point records.
- Stream framing: header, channel word, DAC word, fixed-length trigger data, trailer.
- Sits on the readback/loopback path; feeds an on-chip histogrammer or self-check logic.
- Detects framing errors and resynchronises on the next header.

Parameters:
DATA_WORDS, 2, trigger data words per DAC point (1..4).
HEADER_WORD, 16'h5343, frame header ("SC").
TRAILER_WORD, 16'hFF45, frame trailer.

Ports:
Clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
fifo_empty  in  1  source FIFO empty
fifo_dout  in  16  source FIFO read data, valid 1 cycle after fifo_rd_en
fifo_rd_en  out  1  source FIFO read strobe
rec_valid  out  1  record available
rec_ready  in  1  downstream accepts record when high with rec_valid
rec_mode  out  2  0=64-chn Ctest (0x63), 1=single Ctest (0x43), 2=single input (0x49)
rec_chn  out  6  channel number
rec_dac  out  10  DAC code
rec_data  out  16*DATA_WORDS  trigger data, word 0 in LSBs
frame_done  out  1  one-cycle pulse on accepted trailer
frame_err  out  1  sticky framing error; cleared on next valid header
point_cnt  out  16  records accepted in current frame, saturating

Behaviour:
- Reset: all outputs 0; state HUNT.
- Read engine: fifo_rd_en=1 when ~fifo_empty, no read pending, and not stalled; word_v asserts next cycle. At most one outstanding read, so max 1 word per 2 cycles. Stall = rec_valid & ~rec_ready.
- States, one word consumed per word_v:
  - HUNT: word==HEADER_WORD -> CHN, clear frame_err and point_cnt; otherwise discard.
  - CHN: word[15:8] in {0x63,0x43,0x49} and word[7:6]==0 -> latch mode/chn, go DAC; otherwise error.
  - DAC: word[15:12]==4'hD and word[11:10]==0 -> latch dac, clear data index, go DATA; otherwise error.
  - DATA: store word at index; after DATA_WORDS words assert rec_valid, go NEXT. Data content is never tag-checked.
  - NEXT: enter only once the record is accepted. Then: top nibble 0xD -> DAC path; chn tag -> CHN path; TRAILER_WORD -> frame_done pulse, go HUNT; HEADER_WORD -> error then CHN; anything else -> error.
- Error action: frame_err<=1, drop partial record, go HUNT (except the header case above).
- rec_valid rises the cycle after the last data word. rec_* fields are held stable until the rec_valid&rec_ready cycle. rec_valid clears that cycle; point_cnt increments (saturates at 16'hFFFF).
- Simultaneous accept and new word: impossible by construction (reads stalled while rec_valid).
- Reset mid-frame: immediate return to HUNT; the FIFO is not flushed.
- Single-channel frames carry one channel word; 64-chn frames carry 64. The parser does not distinguish them structurally.

Optional Feature:
SCURVE_PARSER_SEQCHK_EN
- Defined: adds seq_err out 1 (sticky, cleared on header).
  - DAC codes must start at 0 after each channel word and increment by 1 to 1023.
  - A channel word after a record must follow a DAC of 1023.
  - In mode 0, channel numbers must increment from 0.
  - A violation sets seq_err; parsing continues.
- Undefined: no seq_err port, no checking logic.

Decomposition:
- Shared package scurve_pkg: HEADER/TRAILER words, tag bytes 0x63/0x43/0x49, DAC nibble 4'hD, rec_mode encodings. The existing test controller uses the same package.
- One sub-module, scurve_fifo_reader: single-outstanding read handshake producing word/word_v with stall input.

Test Plan:
- Single-channel Ctest frame, DATA_WORDS=2: 5343, 4305, D000, 0011, 0022, FF45 -> one record, mode=1, chn=5, dac=0, rec_data=0x0022_0011; frame_done pulse; point_cnt=1; frame_err=0.
- Full 64-chn frame, 64x1024 points -> 65536 records in order; point_cnt saturates at FFFF; with SEQCHK_EN, seq_err=0.
- Backpressure: rec_ready low 20 cycles after rec_valid -> fifo_rd_en stays 0, rec_* stable; resumes 1 cycle after accept.
- Bad tag: 5343, 7705 -> frame_err=1, state HUNT. Next 5343, 6300, D000, ... -> frame_err cleared, records resume.
- Data word equal to 0xD123 or 0xFF45 inside DATA -> treated as data, no framing change.
- SEQCHK_EN: DAC sequence 000, 001, 003 -> seq_err=1 after third DAC word; records still output. Reset mid-DATA -> outputs 0, HUNT, next header parsed cleanly.
